// File: rtl/fwd_hazard_unit_pkg.sv
// fwd_hazard_unit_pkg: shared forwarding codes, register width and EX/MEM tracker entry
package fwd_hazard_unit_pkg;
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             memread;
    logic [REG_W-1:0] rd;
  } entry_t;
  function automatic logic writes(input entry_t e, input logic [REG_W-1:0] r);
    return e.valid && e.regwrite && e.rd == r && r != REG_ZERO;
  endfunction
endpackage

// File: rtl/fwd_select.sv
// fwd_select: operand-select code for one source register, nearer stage wins
module fwd_select
  import fwd_hazard_unit_pkg::*;
(
  input  logic [REG_W-1:0] r,
  input  logic             used,
  input  entry_t           ex,
  input  entry_t           mem,
  output logic [1:0]       sel
);
  assign sel = (!used || r == REG_ZERO) ? FWD_REG :
               writes(ex, r)            ? FWD_EXMEM :
               writes(mem, r)           ? FWD_MEMWB : FWD_REG;
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX/MEM destination tracker, registered forwarding selects and load-use stall
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NUM_STALL_BITS = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      id_valid,
  input  logic [REG_W-1:0]          id_rs,
  input  logic [REG_W-1:0]          id_rt,
  input  logic                      id_uses_rs,
  input  logic                      id_uses_rt,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  input  logic [REG_W-1:0]          id_rd,
  input  logic                      hold,
  input  logic                      flush,
  output logic                      stall,
  output logic [1:0]                fwd_a_sel,
  output logic [1:0]                fwd_b_sel,
  output logic [NUM_STALL_BITS-1:0] stall_count
);
  entry_t     ex, mem;
  logic [1:0] sel_a, sel_b;
  logic       advance;
  // a load in EX feeding an ID source cannot be forwarded yet; hold is deliberately absent here
  assign stall = id_valid && !flush && ex.memread && writes(ex, ex.rd) &&
                 ((id_uses_rs && id_rs == ex.rd) || (id_uses_rt && id_rt == ex.rd));
  assign advance = id_valid && !stall && !flush;
  fwd_select u_sel_a (.r(id_rs), .used(id_uses_rs), .ex(ex), .mem(mem), .sel(sel_a));
  fwd_select u_sel_b (.r(id_rt), .used(id_uses_rt), .ex(ex), .mem(mem), .sel(sel_b));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ex          <= '0;
      mem         <= '0;
      fwd_a_sel   <= FWD_REG;
      fwd_b_sel   <= FWD_REG;
      stall_count <= '0;
    end else if (!hold) begin
      mem       <= ex;
      ex        <= advance ? entry_t'{1'b1, id_regwrite, id_memread, id_rd} : '0;
      fwd_a_sel <= advance ? sel_a : FWD_REG;
      fwd_b_sel <= advance ? sel_b : FWD_REG;
      if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed and random stimulus against an instruction-history model
module tb_fwd_hazard_unit;
  logic clk = 0, reset_n = 0;
  logic id_valid = 0, id_uses_rs = 0, id_uses_rt = 0, id_regwrite = 0, id_memread = 0;
  logic hold = 0, flush = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_rd = 0;
  logic stall, stall4;
  logic [1:0] a_sel, b_sel, a_sel4, b_sel4;
  logic [15:0] cnt16;
  logic [3:0] cnt4;
  always #5 clk = ~clk;
  fwd_hazard_unit #(.NUM_STALL_BITS(16)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_rd(id_rd), .hold(hold), .flush(flush),
    .stall(stall), .fwd_a_sel(a_sel), .fwd_b_sel(b_sel), .stall_count(cnt16));
  fwd_hazard_unit #(.NUM_STALL_BITS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_rd(id_rd), .hold(hold), .flush(flush),
    .stall(stall4), .fwd_a_sel(a_sel4), .fwd_b_sel(b_sel4), .stall_count(cnt4));
  // hist[0] is the instruction now in EX, hist[1] the one in MEM
  typedef struct {bit v, rw, mr; int rd;} ins_t;
  ins_t hist[2];
  int exp_a, exp_b, n_stall, n_cmp, n_err;
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit writes(input int i, input int r);
    return hist[i].v && hist[i].rw && hist[i].rd == r && r != 0;
  endfunction
  function automatic int pick(input int r, input bit u);
    if (!u || r == 0) return 0;
    if (writes(0, r)) return 1;
    if (writes(1, r)) return 2;
    return 0;
  endfunction
  function automatic bit m_stall();
    int rd = hist[0].rd;
    return id_valid && !flush && hist[0].mr && writes(0, rd) &&
           ((id_uses_rs && int'(id_rs) == rd) || (id_uses_rt && int'(id_rt) == rd));
  endfunction
  task automatic m_clear();
    hist[0] = '{0, 0, 0, 0};
    hist[1] = '{0, 0, 0, 0};
    exp_a = 0; exp_b = 0; n_stall = 0;
  endtask
  task automatic check_outs(input string tag);
    chk({tag, "_a"}, a_sel, exp_a);
    chk({tag, "_b"}, b_sel, exp_b);
    chk({tag, "_a4"}, a_sel4, exp_a);
    chk({tag, "_b4"}, b_sel4, exp_b);
    chk({tag, "_cnt16"}, cnt16, n_stall > 65535 ? 65535 : n_stall);
    chk({tag, "_cnt4"}, cnt4, n_stall > 15 ? 15 : n_stall);
  endtask
  task automatic cycle();
    bit st, adv;
    ins_t nxt;
    @(negedge clk);
    st = m_stall();
    chk("stall", stall, st);
    chk("stall4", stall4, st);
    if (!hold) begin
      adv = id_valid && !st && !flush;
      exp_a = adv ? pick(id_rs, id_uses_rs) : 0;
      exp_b = adv ? pick(id_rt, id_uses_rt) : 0;
      nxt = adv ? '{1, id_regwrite, id_memread, int'(id_rd)} : '{0, 0, 0, 0};
      n_stall += st;
      hist[1] = hist[0];
      hist[0] = nxt;
    end
    @(posedge clk);
    #1;
    check_outs("cyc");
  endtask
  task automatic set_in(input bit v, input int rd, input int rs, input bit urs,
                        input int rt, input bit urt, input bit rw, input bit mr);
    id_valid = v; id_rd = 5'(rd); id_rs = 5'(rs); id_uses_rs = urs;
    id_rt = 5'(rt); id_uses_rt = urt; id_regwrite = rw; id_memread = mr;
    hold = 0; flush = 0;
  endtask
  task automatic alu(input int rd, input int rs, input int rt);
    set_in(1, rd, rs, 1, rt, 1, 1, 0);
  endtask
  task automatic lw(input int rd, input int rs);
    set_in(1, rd, rs, 1, 0, 0, 1, 1);
  endtask
  task automatic do_reset(input string tag);
    #2;
    reset_n = 0;
    #1;
    m_clear();
    chk({tag, "_stall"}, stall, 0);
    check_outs(tag);
    @(posedge clk);
    #1;
    reset_n = 1;
  endtask
  initial begin
    int c0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    chk("rst_stall", stall, 0);
    check_outs("rst");
    alu(3, 1, 2); cycle();
    alu(4, 3, 5); cycle();
    chk("chain_a", a_sel, 1);
    set_in(1, 6, 5, 1, 3, 1, 1, 0); cycle();
    chk("chain_b", b_sel, 2);
    lw(8, 1); cycle();
    alu(9, 8, 1);
    #1;
    chk("pre_rst_stall", stall, 1);
    do_reset("midrst");
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle();
    lw(8, 1); cycle();
    alu(9, 8, 1);
    #1;
    chk("lu_stall", stall, 1);
    cycle();
    chk("lu_bubble_a", a_sel, 0);
    chk("lu_cnt", cnt16, 1);
    cycle();
    chk("lu_fwd_a", a_sel, 2);
    chk("lu_cnt_after", cnt16, 1);
    alu(0, 1, 2); cycle();
    alu(10, 0, 0); cycle();
    chk("zero_a", a_sel, 0);
    chk("zero_b", b_sel, 0);
    alu(7, 1, 2); cycle();
    alu(7, 3, 4); cycle();
    alu(11, 7, 1); cycle();
    chk("near_a", a_sel, 1);
    lw(8, 1); cycle();
    alu(9, 8, 8);
    hold = 1;
    c0 = n_stall;
    repeat (3) begin
      cycle();
      chk("hold_stall", stall, 1);
    end
    chk("hold_cnt", cnt16, c0);
    hold = 0;
    cycle();
    cycle();
    chk("hold_fwd_a", a_sel, 2);
    chk("hold_fwd_b", b_sel, 2);
    lw(8, 1); cycle();
    alu(9, 8, 1);
    flush = 1;
    #1;
    chk("flush_stall", stall, 0);
    cycle();
    chk("flush_a", a_sel, 0);
    chk("flush_b", b_sel, 0);
    do_reset("satrst");
    repeat (20) begin
      lw(8, 1); cycle();
      alu(9, 8, 1); cycle(); cycle();
    end
    chk("sat16", cnt16, 20);
    chk("sat4", cnt4, 15);
    repeat (3000) begin
      set_in($urandom % 8 != 0, $urandom % 8, $urandom % 8, $urandom % 4 != 0,
             $urandom % 8, $urandom % 4 != 0, $urandom % 4 != 0, $urandom % 3 == 0);
      hold = $urandom % 7 == 0;
      flush = $urandom % 7 == 0;
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
